// File: rtl/multicycle_pkg.sv
// Shared definitions for the 8-bit multicycle CPU: opcodes, FSM state codes,
// execute-state selection and the seven-segment glyph table.
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_FETCH2 = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD1  = 4'd3,
    ST_LOAD2  = 4'd4,
    ST_STORE  = 4'd5,
    ST_ALU    = 4'd6,
    ST_BR     = 4'd7,
    ST_HALT   = 4'd8,
    ST_NOP    = 4'd9
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [2:0] OP3_ORI   = 3'b111;
  localparam logic [2:0] OP3_SHIFT = 3'b011;

  // ORI and SHIFT are identified by the low three bits and take precedence.
  function automatic state_e exec_state(input logic [7:0] ir);
    state_e st;
    st = ST_NOP;
    if (ir[2:0] == OP3_ORI || ir[2:0] == OP3_SHIFT) begin
      st = ST_ALU;
    end else begin
      case (ir[3:0])
        OP_LOAD:                st = ST_LOAD1;
        OP_STORE:               st = ST_STORE;
        OP_ADD, OP_SUB, OP_NAND: st = ST_ALU;
        OP_BZ, OP_BNZ, OP_BPZ:   st = ST_BR;
        OP_STOP:                st = ST_HALT;
        default:                st = ST_NOP;
      endcase
    end
    return st;
  endfunction

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/multicycle_cpu_hex7seg.sv
// One seven-segment digit driver: 4-bit value in, active-low glyph out.
module hex7seg
  import multicycle_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_glyph(nibble);
endmodule

// File: rtl/multicycle_cpu.sv
// 8-bit multicycle CPU with a shared 256x8 instruction/data memory, four
// registers K0..K3 and Z/N flags; state is mirrored on the HEX digits and LEDs.
module multicycle_cpu
  import multicycle_pkg::*;
#(
  parameter string MEM_INIT = "program.hex",
  parameter int    DW       = 8
) (
  input  logic [1:0]  KEY,
  input  logic [1:0]  SW,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [7:0]  LEDG,
  output logic [17:0] LEDR
);

  logic clk, srst;
  assign clk  = KEY[1];
  assign srst = KEY[0];

  state_e        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [DW-1:0] k_q [4];
  logic [DW-1:0] k_d [4];
  logic          z_q, z_d, n_q, n_d;

  logic [DW-1:0] mem [0:(1<<DW)-1];
  logic [DW-1:0] mem_rd_q, mem_addr, mem_wdata, alu_res, k_sel;
  logic          mem_we, halted, br_taken;
  logic [1:0]    ra, rb, alu_dst;

  assign ra        = ir_q[7:6];
  assign rb        = ir_q[5:4];
  assign halted    = (state_q == ST_HALT);
  assign mem_we    = (state_q == ST_STORE);
  assign mem_addr  = (state_q == ST_FETCH) ? pc_q : k_q[rb];
  assign mem_wdata = a_q;

  // A store is suppressed on a reset edge so reset cleanly aborts it.
  always_ff @(posedge clk) begin
    if (mem_we && !srst) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rd_q <= mem[mem_addr];
  end

  always_comb begin
    alu_res = a_q;
    alu_dst = ra;
    if (ir_q[2:0] == OP3_ORI) begin
      alu_res = k_q[1] | DW'(ir_q[7:3]);
      alu_dst = 2'd1;
    end else if (ir_q[2:0] == OP3_SHIFT) begin
      // Negative imm3 shifts right by its magnitude (1..4).
      if (!ir_q[5]) alu_res = a_q << ir_q[4:3];
      else          alu_res = a_q >> (3'd0 - ir_q[5:3]);
    end else begin
      case (ir_q[3:0])
        OP_ADD:  alu_res = a_q + b_q;
        OP_SUB:  alu_res = a_q - b_q;
        OP_NAND: alu_res = ~(a_q & b_q);
        default: alu_res = a_q;
      endcase
    end
  end

  always_comb begin
    case (ir_q[3:0])
      OP_BZ:   br_taken = z_q;
      OP_BNZ:  br_taken = !z_q;
      OP_BPZ:  br_taken = !n_q;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    z_d     = z_q;
    n_d     = n_q;
    case (state_q)
      ST_FETCH:  state_d = ST_FETCH2;
      ST_FETCH2: begin
        ir_d    = mem_rd_q;
        pc_d    = pc_q + DW'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        a_d     = k_q[ra];
        b_d     = k_q[rb];
        state_d = exec_state(ir_q);
      end
      ST_LOAD1:  state_d = ST_LOAD2;
      ST_LOAD2: begin
        k_d[ra] = mem_rd_q;
        state_d = ST_FETCH;
      end
      ST_ALU: begin
        k_d[alu_dst] = alu_res;
        z_d          = (alu_res == '0);
        n_d          = alu_res[DW-1];
        state_d      = ST_FETCH;
      end
      ST_BR: begin
        if (br_taken) pc_d = pc_q + {{(DW-4){ir_q[7]}}, ir_q[7:4]};
        state_d = ST_FETCH;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '{default: '0};
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  logic [3:0] digit [8];
  logic [6:0] seg   [8];

  assign k_sel = k_q[SW];

  always_comb begin
    digit[0] = k_sel[3:0];
    digit[1] = k_sel[7:4];
    digit[2] = pc_q[3:0];
    digit[3] = pc_q[7:4];
    digit[4] = ir_q[3:0];
    digit[5] = ir_q[7:4];
    digit[6] = 4'(state_q);
    digit[7] = 4'h0;
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_hex
      hex7seg u_hex (
        .nibble (digit[gi]),
        .seg    (seg[gi])
      );
    end
  endgenerate

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];
  assign HEX6 = seg[6];
  assign HEX7 = seg[7];

  assign LEDG = {halted, z_q, n_q, 1'b0, 4'(state_q)};
  assign LEDR = {mem_we, halted, mem_addr, mem_wdata};

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed scenarios plus random programs compared against an instruction-level
// model of the CPU, observed through the HEX digits and LEDs.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sw  = 2'd0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [7:0]  ledg;
  logic [17:0] ledr;

  multicycle_cpu dut (
    .KEY  ({clk, rst}),
    .SW   (sw),
    .HEX0 (hex0), .HEX1 (hex1), .HEX2 (hex2), .HEX3 (hex3),
    .HEX4 (hex4), .HEX5 (hex5), .HEX6 (hex6), .HEX7 (hex7),
    .LEDG (ledg),
    .LEDR (ledr)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  // Instruction-level reference state
  logic [7:0] m_mem [256];
  logic [7:0] m_k   [4];
  logic [7:0] m_pc;
  logic       m_z, m_n, m_halt;

  int         we_count = 0;
  logic [7:0] we_addr, we_data;

  always @(negedge clk) begin
    if (ledr[17] === 1'b1) begin
      we_count++;
      we_addr = ledr[15:8];
      we_data = ledr[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] seg2nib(input logic [6:0] s);
    logic [3:0] r;
    r = 4'bxxxx;
    for (int i = 0; i < 16; i++) if (GLYPH[i] === s) r = 4'(i);
    return r;
  endfunction

  function automatic logic [7:0] pair(input logic [6:0] hi, input logic [6:0] lo);
    return {seg2nib(hi), seg2nib(lo)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_k(input int idx, output logic [7:0] v);
    sw = 2'(idx);
    #1;
    v = pair(hex1, hex0);
  endtask

  // Load m_mem into the DUT while held in reset, then release.
  task automatic start_prog();
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 256; i++) dut.mem[i] = m_mem[i];
    tick(1);
    rst = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) m_mem[i] = v;
  endtask

  task automatic m_reset();
    m_pc = 8'h00;
    for (int i = 0; i < 4; i++) m_k[i] = 8'h00;
    m_z = 1'b0;
    m_n = 1'b0;
    m_halt = 1'b0;
  endtask

  // Executes one instruction; cyc is the clock count until the next fetch (or halt).
  task automatic m_step(output int cyc);
    logic [7:0] ir, r;
    int ra, rb, sh, off;
    logic wr;
    ir = m_mem[m_pc];
    m_pc = m_pc + 8'd1;
    ra = int'(ir[7:6]);
    rb = int'(ir[5:4]);
    cyc = 4;
    wr = 1'b0;
    r = 8'h00;
    if (ir[2:0] == 3'b111) begin
      r = m_k[1] | {3'b000, ir[7:3]};
      m_k[1] = r;
      wr = 1'b1;
    end else if (ir[2:0] == 3'b011) begin
      sh = int'($signed(ir[5:3]));
      if (sh > 0)      r = m_k[ra] << sh;
      else if (sh < 0) r = m_k[ra] >> (-sh);
      else             r = m_k[ra];
      m_k[ra] = r;
      wr = 1'b1;
    end else begin
      off = int'($signed(ir[7:4]));
      case (ir[3:0])
        4'd0:  begin m_k[ra] = m_mem[m_k[rb]]; cyc = 5; end
        4'd2:  m_mem[m_k[rb]] = m_k[ra];
        4'd4:  begin r = m_k[ra] + m_k[rb]; m_k[ra] = r; wr = 1'b1; end
        4'd6:  begin r = m_k[ra] - m_k[rb]; m_k[ra] = r; wr = 1'b1; end
        4'd8:  begin r = ~(m_k[ra] & m_k[rb]); m_k[ra] = r; wr = 1'b1; end
        4'd5:  if (m_z)  m_pc = m_pc + 8'(off);
        4'd9:  if (!m_z) m_pc = m_pc + 8'(off);
        4'd13: if (!m_n) m_pc = m_pc + 8'(off);
        4'd1:  m_halt = 1'b1;
        default: ;
      endcase
    end
    if (wr) begin
      m_z = (r == 8'h00);
      m_n = r[7];
    end
  endtask

  initial begin
    logic [7:0] v;
    int cyc, diffs;

    // 1: reset
    fill_mem(8'h01);
    for (int i = 0; i < 256; i++) dut.mem[i] = m_mem[i];
    rst = 1'b1;
    tick(2);
    check("rst_pc", pair(hex3, hex2), 8'h00);
    check("rst_hex3", hex3, 7'h40);
    check("rst_hex2", hex2, 7'h40);
    check("rst_ledg", ledg, 8'h00);
    check("rst_hex76", {hex7, hex6}, {7'h40, 7'h40});
    check("rst_ir", pair(hex5, hex4), 8'h00);

    // 2: ORI 3 ; STOP
    fill_mem(8'h01);
    m_mem[0] = 8'h1F;
    start_prog();
    tick(8);
    read_k(1, v);
    check("t2_k1", v, 8'h03);
    check("t2_hex10", {hex1, hex0}, {7'h40, 7'h30});
    check("t2_ledg", ledg, 8'h88);
    check("t2_pc", pair(hex3, hex2), 8'h02);
    tick(6);
    check("t2_halt_pc", pair(hex3, hex2), 8'h02);
    check("t2_halt_state", ledg[3:0], 4'd8);

    // 3: ORI 7 ; ADD K1,K1 ; STOP
    fill_mem(8'h01);
    m_mem[0] = 8'h3F;
    m_mem[1] = 8'h54;
    start_prog();
    tick(12);
    read_k(1, v);
    check("t3_k1", v, 8'h0E);
    check("t3_flags", ledg[7:5], 3'b100);

    // 4: K1=0x80, SUB K1,K1, BZ +2 skips two ORIs
    fill_mem(8'h01);
    m_mem[0] = 8'h87;
    m_mem[1] = 8'h5B;
    m_mem[2] = 8'h56;
    m_mem[3] = 8'h25;
    m_mem[4] = 8'h0F;
    m_mem[5] = 8'h0F;
    start_prog();
    tick(8);
    read_k(1, v);
    check("t4_k1_80", v, 8'h80);
    check("t4_n", ledg[6:5], 2'b01);
    tick(4);
    read_k(1, v);
    check("t4_k1_00", v, 8'h00);
    check("t4_z", ledg[6:5], 2'b10);
    tick(4);
    check("t4_br_pc", pair(hex3, hex2), 8'h06);
    tick(4);
    read_k(1, v);
    check("t4_k1_final", v, 8'h00);
    check("t4_halt", {ledg[7], pair(hex3, hex2)}, {1'b1, 8'h07});

    // 5: LOAD from M[0x0A], STORE to M[0x20]
    fill_mem(8'h01);
    m_mem[0] = 8'h57;
    m_mem[1] = 8'h94;
    m_mem[2] = 8'h20;
    m_mem[3] = 8'h56;
    m_mem[4] = 8'h87;
    m_mem[5] = 8'h4B;
    m_mem[6] = 8'h12;
    m_mem[10] = 8'hA5;
    start_prog();
    we_count = 0;
    tick(36);
    check("t5_we_cycles", we_count, 1);
    check("t5_we_addr", we_addr, 8'h20);
    check("t5_we_data", we_data, 8'hA5);
    check("t5_mem20", dut.mem[8'h20], 8'hA5);
    read_k(0, v);
    check("t5_k0", v, 8'hA5);
    read_k(2, v);
    check("t5_k2", v, 8'h0A);
    check("t5_halt", ledg[7], 1'b1);

    // 6: reset during LOAD2
    fill_mem(8'h01);
    m_mem[0] = 8'h1F;
    m_mem[1] = 8'h10;
    start_prog();
    tick(8);
    check("t6_in_load2", ledg[3:0], 4'd4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_ledg", ledg, 8'h00);
    check("t6_pc", pair(hex3, hex2), 8'h00);
    check("t6_ir", pair(hex5, hex4), 8'h00);
    for (int i = 0; i < 4; i++) begin
      read_k(i, v);
      check($sformatf("t6_k%0d", i), v, 8'h00);
    end
    tick(1);
    check("t6_fetch2", ledg[3:0], 4'd1);

    // reset on the STORE edge must not write memory
    fill_mem(8'h01);
    m_mem[0] = 8'h1F;
    m_mem[1] = 8'h52;
    start_prog();
    tick(7);
    check("t6b_in_store", ledg[3:0], 4'd5);
    rst = 1'b1;
    tick(1);
    check("t6b_mem3", dut.mem[3], 8'h01);

    // random programs against the instruction-level model
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
      start_prog();
      m_reset();
      for (int n = 0; n < 30 && !m_halt; n++) begin
        m_step(cyc);
        tick(cyc);
        check("rnd_state", ledg[3:0], m_halt ? 4'd8 : 4'd0);
        check("rnd_flags", ledg[7:5], {m_halt, m_z, m_n});
        check("rnd_pc", pair(hex3, hex2), m_pc);
        for (int j = 0; j < 4; j++) begin
          read_k(j, v);
          check($sformatf("rnd_k%0d", j), v, m_k[j]);
        end
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (dut.mem[i] !== m_mem[i]) diffs++;
      check("rnd_mem", diffs, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
